prog_fsm_timer: RTL and testbench

PROG_FSM_TIMER -- requirements
Module: prog_fsm_timer

---
 rtl/prog_fsm_timer.sv | 147 ++++++++++++++
 tb/tb_prog_fsm_timer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_fsm_timer.sv
// prog_fsm_timer: programmable one-shot / periodic count timer.
//
// A start request in IDLE latches a terminal value and a mode. The block then
// counts 0..term in RUN (term+1 cycles), spends one cycle in DONE, and either
// returns to IDLE (one-shot) or restarts counting from 0 (periodic). The pause
// input freezes counting in HOLD. The stop input aborts to IDLE from any state.
//
// Parameters
//   WIDTH    : count / terminal-value width in bits (2..16)
//   DEF_MODE : mode register reset value (0 one-shot, 1 periodic)
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst_n    : asynchronous active-low reset
//   start    : level, sampled only in IDLE, launches a sequence
//   stop     : synchronous abort, highest priority, any state
//   pause    : freezes counting while high
//   mode     : 0 one-shot, 1 periodic; sampled with start
//   load_val : terminal count; sampled with start
//   count    : current count value (registered)
//   state    : IDLE=00, RUN=01, DONE=10, HOLD=11
//   busy     : high in RUN or HOLD
//   done     : high exactly while in DONE
module prog_fsm_timer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEF_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done
);

  // Encoding is visible on the state port, so values are fixed explicitly.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10,
    StHold = 2'b11
  } state_e;

  localparam logic ModeRst = (DEF_MODE != 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q,  term_d;
  logic             mode_q,  mode_d;

  logic at_term;
  assign at_term = (count_q == term_q);

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = term_q;
    mode_d  = mode_q;

    if (stop) begin
      // Abort wins over start, pause and terminal detection.
      state_d = StIdle;
      count_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          count_d = '0;
          if (start) begin
            term_d  = load_val;
            mode_d  = mode;
            state_d = StRun;
          end
        end

        StRun: begin
          if (pause) begin
            // Pause takes precedence over the terminal check; count frozen.
            state_d = StHold;
          end else if (at_term) begin
            state_d = StDone;
            count_d = '0;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end

        StHold: begin
          // The RUN cycle that was interrupted by pause completes on release,
          // so the sequence is stretched by exactly the number of HOLD cycles.
          // Holding at term therefore releases straight into DONE.
          if (!pause) begin
            if (at_term) begin
              state_d = StDone;
              count_d = '0;
            end else begin
              state_d = StRun;
              count_d = count_q + WIDTH'(1);
            end
          end
        end

        StDone: begin
          count_d = '0;
          state_d = mode_q ? StRun : StIdle;
        end

        default: begin
          state_d = StIdle;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      term_q  <= '0;
      mode_q  <= ModeRst;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
      mode_q  <= mode_d;
    end
  end

  // Outputs are decoded from registers only.
  assign count = count_q;
  assign state = state_q;
  assign busy  = (state_q == StRun) || (state_q == StHold);
  assign done  = (state_q == StDone);

  // Structural invariants.
  a_count_le_term : assert property (@(posedge clk) disable iff (!rst_n)
    busy |-> (count_q <= term_q));
  a_count_zero_idle_done : assert property (@(posedge clk) disable iff (!rst_n)
    !busy |-> (count_q == '0));

endmodule

// File: tb/tb_prog_fsm_timer.sv
// Directed self-checking bench for prog_fsm_timer (WIDTH=4, DEF_MODE=0).
module tb_prog_fsm_timer;

  localparam int unsigned W = 4;

  localparam logic [1:0] SIdle = 2'b00;
  localparam logic [1:0] SRun  = 2'b01;
  localparam logic [1:0] SDone = 2'b10;
  localparam logic [1:0] SHold = 2'b11;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         stop;
  logic         pause;
  logic         mode;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic [1:0]   state;
  logic         busy;
  logic         done;

  int n_checks;
  int n_pass;
  int cyc;

  prog_fsm_timer #(
    .WIDTH    (W),
    .DEF_MODE (0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .mode     (mode),
    .load_val (load_val),
    .count    (count),
    .state    (state),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input int cnt);
    logic bsy;
    logic dn;
    bsy = (st == SRun) || (st == SHold);
    dn  = (st == SDone);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".count"}, 32'(count), 32'(cnt));
    check({tag, ".busy"},  32'(busy),  32'(bsy));
    check({tag, ".done"},  32'(done),  32'(dn));
  endtask

  // Raise start for one sampling edge; leaves the DUT on its first RUN cycle.
  task automatic launch(input int lv, input logic md);
    load_val = W'(lv);
    mode     = md;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    load_val = '0;
    mode     = 1'b0;
  endtask

  // load_val=8 one-shot: RUN with count 0..8, DONE, then IDLE.
  task automatic one_shot_8(input string tag);
    launch(8, 1'b0);
    for (int i = 0; i <= 8; i++) begin
      expect_out($sformatf("%s.run%0d", tag, i), SRun, i);
      tick();
    end
    expect_out({tag, ".done"}, SDone, 0);
    tick();
    expect_out({tag, ".idle"}, SIdle, 0);
  endtask

  initial begin
    int  t_done0;
    int  t_done1;
    logic saw_done;

    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    pause    = 1'b0;
    mode     = 1'b0;
    load_val = '0;

    #2;
    expect_out("reset", SIdle, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    expect_out("post_reset_idle", SIdle, 0);

    // One-shot, load 8.
    one_shot_8("oneshot");

    // Pause for 3 cycles at count 2 with load 5: DONE on edge 10 instead of 7.
    launch(5, 1'b0);
    tick();
    tick();
    expect_out("pause.pre", SRun, 2);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("pause.hold%0d", i), SHold, 2);
    end
    pause = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      tick();
      expect_out($sformatf("pause.run%0d", i), SRun, i);
    end
    tick();
    expect_out("pause.done", SDone, 0);
    tick();
    expect_out("pause.idle", SIdle, 0);

    // Periodic, load 3: done every 5 cycles; stop at count 1 ends it.
    launch(3, 1'b1);
    t_done0 = 0;
    t_done1 = 0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i <= 3; i++) begin
        expect_out($sformatf("per.p%0d.run%0d", p, i), SRun, i);
        tick();
      end
      expect_out($sformatf("per.p%0d.done", p), SDone, 0);
      if (p == 0) t_done0 = cyc;
      else        t_done1 = cyc;
      tick();
    end
    check("per.period", 32'(t_done1 - t_done0), 32'd5);
    expect_out("per.restart", SRun, 0);
    tick();
    expect_out("per.cnt1", SRun, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect_out("per.stopped", SIdle, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      saw_done = saw_done | done | busy;
    end
    check("per.no_more_done", 32'(saw_done), 32'd0);

    // Boundary: load 0 gives one RUN cycle then DONE.
    launch(0, 1'b0);
    expect_out("lv0.run", SRun, 0);
    tick();
    expect_out("lv0.done", SDone, 0);
    tick();
    expect_out("lv0.idle", SIdle, 0);

    // Boundary: load 15 counts 0..15 with no wrap.
    launch(15, 1'b0);
    for (int i = 0; i <= 15; i++) begin
      check($sformatf("lv15.cnt%0d", i), 32'(count), 32'(i));
      check($sformatf("lv15.st%0d", i), 32'(state), 32'(SRun));
      tick();
    end
    expect_out("lv15.done", SDone, 0);
    tick();
    expect_out("lv15.idle", SIdle, 0);

    // stop + start in IDLE stays IDLE.
    load_val = W'(5);
    start    = 1'b1;
    stop     = 1'b1;
    tick();
    start    = 1'b0;
    stop     = 1'b0;
    expect_out("stop_start", SIdle, 0);

    // stop + pause in RUN goes to IDLE.
    launch(5, 1'b0);
    tick();
    expect_out("stop_pause.pre", SRun, 1);
    stop  = 1'b1;
    pause = 1'b1;
    tick();
    stop  = 1'b0;
    pause = 1'b0;
    expect_out("stop_pause", SIdle, 0);

    // start during RUN with different load/mode is ignored: term stays 5, one-shot.
    launch(5, 1'b0);
    tick();
    start    = 1'b1;
    load_val = W'(2);
    mode     = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      expect_out($sformatf("start_run.cnt%0d", i), SRun, i);
    end
    start    = 1'b0;
    load_val = '0;
    mode     = 1'b0;
    tick();
    expect_out("start_run.cnt5", SRun, 5);
    tick();
    expect_out("start_run.done", SDone, 0);
    tick();
    expect_out("start_run.idle", SIdle, 0);

    // Async reset at count 4: outputs clear between clock edges, no done pulse.
    launch(8, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    expect_out("areset.pre", SRun, 4);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("areset.now", SIdle, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      saw_done = saw_done | done;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      saw_done = saw_done | done | busy;
    end
    check("areset.no_done", 32'(saw_done), 32'd0);
    expect_out("areset.idle", SIdle, 0);
    one_shot_8("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
